volume_meter: RTL and testbench

//   Parametrised microphone volume meter, successor to the fixed task_4 level logic.

---
 rtl/audio_pkg.sv | 15 +
 rtl/level_quantizer.sv | 29 ++
 rtl/volume_meter.sv | 121 ++++++++++++
 tb/tb_volume_meter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio-path constants and types used by the mic capture and metering blocks.
package audio_pkg;
  localparam int MIC_W          = 12;
  localparam int MIC_MID        = 2048;
  localparam int SAMPLE_RATE_HZ = 20000;

  localparam int LEVELS_DEF = 16;
  localparam int LVL_W_DEF  = $clog2(LEVELS_DEF);
  typedef logic [LVL_W_DEF-1:0] level_t;

  typedef enum logic {
    HOLDING  = 1'b0,
    DECAYING = 1'b1
  } hold_state_e;
endpackage

// File: rtl/level_quantizer.sv
// Maps a window peak onto a saturated level index above the noise floor.
module level_quantizer #(
  parameter  int SAMPLE_W   = 12,
  parameter  int FLOOR      = 2048,
  parameter  int STEP_SHIFT = 7,
  parameter  int LEVELS     = 16,
  localparam int LVL_W      = $clog2(LEVELS)
) (
  input  logic [SAMPLE_W-1:0] i_pk,
  output logic [LVL_W-1:0]    o_lv
);
  localparam logic [SAMPLE_W:0] C_FLOOR = (SAMPLE_W+1)'(FLOOR);
  localparam logic [SAMPLE_W:0] C_MAX   = (SAMPLE_W+1)'(LEVELS-1);

  logic [SAMPLE_W:0] w_pk;
  logic [SAMPLE_W:0] w_diff;
  logic [SAMPLE_W:0] w_step;

  // One extra bit so a peak below the floor is caught by the compare, not wrapped.
  assign w_pk   = {1'b0, i_pk};
  assign w_diff = w_pk - C_FLOOR;
  assign w_step = w_diff >> STEP_SHIFT;

  always_comb begin
    if (w_pk <= C_FLOOR)     o_lv = '0;
    else if (w_step > C_MAX) o_lv = C_MAX[LVL_W-1:0];
    else                     o_lv = w_step[LVL_W-1:0];
  end
endmodule

// File: rtl/volume_meter.sv
// Windowed peak volume meter: accumulates mic peaks, publishes a quantised level,
// keeps a decaying peak-hold marker and drives a bar/dot LED pattern.
//   state    | meaning
//   HOLDING  | hold marker fresh, timer counting published windows
//   DECAYING | timer saturated, marker drops one level per published window
module volume_meter
  import audio_pkg::*;
#(
  parameter  int SAMPLE_W     = MIC_W,
  parameter  int WINDOW       = SAMPLE_RATE_HZ / 5,
  parameter  int LEVELS       = 16,
  parameter  int FLOOR        = MIC_MID,
  parameter  int STEP_SHIFT   = 7,
  parameter  int HOLD_WINDOWS = 5,
  localparam int LVL_W        = $clog2(LEVELS)
) (
  input  logic                CLK,
  input  logic                reset_n,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] mic_sample,
  input  logic                freeze,
  input  logic                dot_mode,
  output logic [LVL_W-1:0]    level,
  output logic [LVL_W-1:0]    hold_level,
  output logic [LEVELS-1:0]   bar,
  output logic                update
);
  localparam int CNT_W = $clog2(WINDOW);
  localparam int TMR_W = $clog2(HOLD_WINDOWS + 1);
  localparam logic [CNT_W-1:0] C_LAST    = CNT_W'(WINDOW - 1);
  localparam logic [TMR_W-1:0] C_TMR_SAT = TMR_W'(HOLD_WINDOWS - 1);
  localparam hold_state_e      S_FRESH   = (HOLD_WINDOWS > 1) ? HOLDING : DECAYING;

  logic [SAMPLE_W-1:0] r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic [SAMPLE_W-1:0] r_pk;
  logic                r_pk_vld;
  logic [LVL_W-1:0]    r_level;
  logic [LVL_W-1:0]    r_hold;
  logic [TMR_W-1:0]    r_timer;
  hold_state_e         r_state;
  logic                r_update;

  logic [SAMPLE_W-1:0] w_max;
  logic [LVL_W-1:0]    w_lv;
  logic [LEVELS-1:0]   w_bar;

  assign w_max = (mic_sample > r_acc) ? mic_sample : r_acc;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_pk     <= '0;
      r_pk_vld <= 1'b0;
    end else begin
      r_pk_vld <= 1'b0;
      if (sample_valid) begin
        if (r_cnt == C_LAST) begin
          r_pk     <= w_max;
          r_pk_vld <= 1'b1;
          r_acc    <= '0;
          r_cnt    <= '0;
        end else begin
          r_acc <= w_max;
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  level_quantizer #(
    .SAMPLE_W  (SAMPLE_W),
    .FLOOR     (FLOOR),
    .STEP_SHIFT(STEP_SHIFT),
    .LEVELS    (LEVELS)
  ) u_quant (
    .i_pk(r_pk),
    .o_lv(w_lv)
  );

  // A frozen result is dropped entirely, so the hold timer only ages on published windows.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_level  <= '0;
      r_hold   <= '0;
      r_timer  <= '0;
      r_state  <= S_FRESH;
      r_update <= 1'b0;
    end else begin
      r_update <= 1'b0;
      if (r_pk_vld && !freeze) begin
        r_level  <= w_lv;
        r_update <= 1'b1;
        if (w_lv >= r_hold) begin
          r_hold  <= w_lv;
          r_timer <= '0;
          r_state <= S_FRESH;
        end else if (r_state == HOLDING) begin
          r_timer <= r_timer + 1'b1;
          if (r_timer + 1'b1 == C_TMR_SAT) r_state <= DECAYING;
        end else begin
          r_hold <= (r_hold != '0) ? r_hold - 1'b1 : '0;
        end
      end
    end
  end

  always_comb begin
    w_bar = '0;
    for (int i = 0; i < LEVELS; i++) begin
      if (dot_mode) w_bar[i] = (i == int'(r_level));
      else          w_bar[i] = (i < int'(r_level)) || ((i == int'(r_hold)) && (r_hold != '0));
    end
  end

  assign level      = r_level;
  assign hold_level = r_hold;
  assign bar        = w_bar;
  assign update     = r_update;
endmodule

// File: tb/tb_volume_meter.sv
// Directed bench for volume_meter with a 4-sample window and 2-window hold.
module tb_volume_meter;
  logic        CLK = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [11:0] mic_sample = '0;
  logic        freeze = 1'b0;
  logic        dot_mode = 1'b0;
  logic [3:0]  level;
  logic [3:0]  hold_level;
  logic [15:0] bar;
  logic        update;

  int n_checks = 0;
  int n_errors = 0;
  int upd_cnt  = 0;
  int upd0     = 0;

  volume_meter #(
    .SAMPLE_W    (12),
    .WINDOW      (4),
    .LEVELS      (16),
    .FLOOR       (2048),
    .STEP_SHIFT  (7),
    .HOLD_WINDOWS(2)
  ) dut (
    .CLK         (CLK),
    .reset_n     (reset_n),
    .sample_valid(sample_valid),
    .mic_sample  (mic_sample),
    .freeze      (freeze),
    .dot_mode    (dot_mode),
    .level       (level),
    .hold_level  (hold_level),
    .bar         (bar),
    .update      (update)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (update) upd_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [11:0] s);
    @(negedge CLK);
    sample_valid = 1'b1;
    mic_sample   = s;
    @(negedge CLK);
    sample_valid = 1'b0;
  endtask

  // Ends two negedges after the closing strobe, when update has already come and gone.
  task automatic window(input logic [11:0] a, input logic [11:0] b,
                        input logic [11:0] c, input logic [11:0] d);
    send(a);
    send(b);
    send(c);
    send(d);
    repeat (2) @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    reset_n = 1'b0;
    @(negedge CLK);
    reset_n = 1'b1;
  endtask

  initial begin
    int exp_h[5] = '{10, 9, 8, 7, 6};

    repeat (3) @(negedge CLK);
    reset_n = 1'b1;

    // 1. mid-window reset discards the partial window
    send(12'd4095);
    send(12'd4095);
    @(posedge CLK);
    #2 reset_n = 1'b0;
    @(negedge CLK);
    reset_n = 1'b1;
    check("t1_level_rst", level, 0);
    check("t1_hold_rst", hold_level, 0);
    check("t1_bar_rst", bar, 0);
    check("t1_upd_rst", update, 0);
    upd0 = upd_cnt;
    window(12'd2048, 12'd2048, 12'd2048, 12'd2048);
    check("t1_upd_count", upd_cnt - upd0, 1);
    check("t1_level", level, 0);

    // 2. peak and latency
    upd0 = upd_cnt;
    send(12'd2100);
    send(12'd3000);
    send(12'd2200);
    @(negedge CLK);
    sample_valid = 1'b1;
    mic_sample   = 12'd2300;
    @(negedge CLK);
    sample_valid = 1'b0;
    check("t2_upd_early", update, 0);
    @(negedge CLK);
    check("t2_upd_pulse", update, 1);
    check("t2_level", level, 7);
    check("t2_hold", hold_level, 7);
    check("t2_bar", bar, 16'h00FF);
    @(negedge CLK);
    check("t2_upd_drop", update, 0);
    check("t2_upd_count", upd_cnt - upd0, 1);

    // 3. saturation and floor
    window(12'd4095, 12'd100, 12'd2000, 12'd3000);
    check("t3_level_sat", level, 15);
    check("t3_bar_sat", bar, 16'hFFFF);
    window(12'd1000, 12'd1000, 12'd1000, 12'd1000);
    check("t3_level_floor", level, 0);
    check("t3_hold_floor", hold_level, 15);
    check("t3_bar_floor", bar, 16'h8000);

    // 4. hold decay and refresh
    do_reset();
    window(12'd2000, 12'd3330, 12'd2100, 12'd2048);
    check("t4_level10", level, 10);
    check("t4_hold_first", hold_level, 10);
    for (int k = 0; k < 5; k++) begin
      window(12'd2048, 12'd2048, 12'd2048, 12'd2048);
      check($sformatf("t4_hold_q%0d", k), hold_level, exp_h[k]);
    end
    window(12'd2900, 12'd2048, 12'd2048, 12'd2048);
    check("t4_level6", level, 6);
    check("t4_hold_refresh", hold_level, 6);
    window(12'd2048, 12'd2048, 12'd2048, 12'd2048);
    check("t4_hold_keep", hold_level, 6);
    window(12'd2048, 12'd2048, 12'd2048, 12'd2048);
    check("t4_hold_decay", hold_level, 5);

    // 5. freeze
    @(negedge CLK);
    freeze = 1'b1;
    upd0 = upd_cnt;
    window(12'd3600, 12'd3600, 12'd3600, 12'd3600);
    window(12'd3600, 12'd3600, 12'd3600, 12'd3600);
    check("t5_upd_frozen", upd_cnt - upd0, 0);
    check("t5_level_frozen", level, 0);
    check("t5_hold_frozen", hold_level, 5);
    freeze = 1'b0;
    upd0 = upd_cnt;
    window(12'd3600, 12'd2048, 12'd2048, 12'd2048);
    check("t5_upd_thaw", upd_cnt - upd0, 1);
    check("t5_level_thaw", level, 12);
    check("t5_hold_thaw", hold_level, 12);

    // 6. dot mode
    window(12'd2700, 12'd2048, 12'd2048, 12'd2048);
    dot_mode = 1'b1;
    #1;
    check("t6_bar_dot", bar, 16'h0020);
    dot_mode = 1'b0;
    #1;
    check("t6_bar_therm", bar, 16'h101F);
    check("t6_level", level, 5);
    check("t6_hold", hold_level, 12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
